// File: rtl/fare_meter_ctrl_pkg.sv
// Shared definitions for the taxi fare meter controller: FSM and source encodings,
// BCD limit, default tariff constants and the pending-event counter update rule.
package fare_meter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADD  = 2'd2,
        ST_HOLD = 2'd3
    } fare_state_e;

    typedef enum logic {
        SRC_DIST = 1'b0,
        SRC_TIME = 1'b1
    } fare_src_e;

    localparam logic [15:0] BCD_MAX       = 16'h9999;
    localparam logic [15:0] DEF_BASE_FARE = 16'h0080;
    localparam logic [3:0]  DEF_DIST_STEP = 4'd8;
    localparam logic [3:0]  DEF_TIME_STEP = 4'd4;

    // Returns {drop, new_count}: the service decrement is applied before the new
    // event, so a full counter that is also being served absorbs the event.
    function automatic logic [2:0] pend_update(input logic [1:0] cnt,
                                               input logic       dec,
                                               input logic       ev);
        logic [1:0] base;
        logic       drop;
        base = cnt - {1'b0, dec};
        drop = 1'b0;
        if (ev) begin
            if (base == 2'd3) begin
                drop = 1'b1;
            end else begin
                base = base + 2'd1;
            end
        end
        return {drop, base};
    endfunction

endpackage

// File: rtl/fare_meter_ctrl_bcd_step.sv
// Combinational 4-digit packed-BCD adder of a single BCD digit onto the fare,
// saturating at 9999 when the top digit carries out.
module fare_bcd_step
    import fare_meter_ctrl_pkg::*;
(
    input  logic [15:0] a,
    input  logic [3:0]  b,
    output logic [15:0] sum,
    output logic        sat
);

    logic [15:0] raw;
    logic        carry;
    logic [4:0]  digit;
    logic [3:0]  addend;

    always_comb begin
        raw    = 16'h0000;
        carry  = 1'b0;
        digit  = 5'd0;
        addend = 4'd0;
        for (int i = 0; i < 4; i++) begin
            addend = (i == 0) ? b : 4'd0;
            digit  = {1'b0, a[i*4 +: 4]} + {1'b0, addend} + {4'd0, carry};
            if (digit > 5'd9) begin
                digit = digit - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[i*4 +: 4] = digit[3:0];
        end
        sat = carry;
        sum = carry ? BCD_MAX : raw;
    end

endmodule

// File: rtl/fare_meter_ctrl.sv
// Taxi fare meter: counts distance / waiting-time pulses while a trip runs and
// adds the matching BCD step to the fare, one add per ADD visit.
module fare_meter_ctrl
    import fare_meter_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_FARE = DEF_BASE_FARE,
    parameter logic [3:0]  DIST_STEP = DEF_DIST_STEP,
    parameter logic [3:0]  TIME_STEP = DEF_TIME_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        add_distance,
    input  logic        add_time,
    output logic [15:0] fare,
    output logic        running,
    output logic        busy,
    output logic        ovf,
    output logic        drop_err,
    output fare_state_e fsm_state
);

    fare_state_e state, state_next;
    fare_src_e   sel, sel_next;
    logic [3:0]  step_q, step_next;
    logic [15:0] fare_next;
    logic [1:0]  cnt_d, cnt_d_next, cnt_t, cnt_t_next;
    logic        prev_d, prev_t;
    logic        ovf_next, drop_next;
    logic        ev_d, ev_t, dec_d, dec_t;
    logic [2:0]  upd_d, upd_t;
    logic [15:0] step_sum;
    logic        step_sat;

    assign ev_d  = add_distance & ~prev_d;
    assign ev_t  = add_time & ~prev_t;
    assign dec_d = (state == ST_ADD) && (sel == SRC_DIST);
    assign dec_t = (state == ST_ADD) && (sel == SRC_TIME);
    assign upd_d = pend_update(cnt_d, dec_d, ev_d);
    assign upd_t = pend_update(cnt_t, dec_t, ev_t);

    fare_bcd_step u_step (
        .a   (fare),
        .b   (step_q),
        .sum (step_sum),
        .sat (step_sat)
    );

    always_comb begin
        state_next = state;
        fare_next  = fare;
        cnt_d_next = cnt_d;
        cnt_t_next = cnt_t;
        sel_next   = sel;
        step_next  = step_q;
        ovf_next   = ovf;
        drop_next  = drop_err;
        case (state)
            ST_IDLE, ST_HOLD: begin
                // stop dominates a simultaneous start
                if (start && !stop) begin
                    state_next = ST_RUN;
                    fare_next  = BASE_FARE;
                    cnt_d_next = 2'd0;
                    cnt_t_next = 2'd0;
                    ovf_next   = 1'b0;
                    drop_next  = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_HOLD;
                    cnt_d_next = 2'd0;
                    cnt_t_next = 2'd0;
                end else begin
                    cnt_d_next = upd_d[1:0];
                    cnt_t_next = upd_t[1:0];
                    drop_next  = drop_err | upd_d[2] | upd_t[2];
                    if (cnt_d != 2'd0) begin
                        state_next = ST_ADD;
                        sel_next   = SRC_DIST;
                        step_next  = DIST_STEP;
                    end else if (cnt_t != 2'd0) begin
                        state_next = ST_ADD;
                        sel_next   = SRC_TIME;
                        step_next  = TIME_STEP;
                    end
                end
            end
            ST_ADD: begin
                fare_next = step_sum;
                ovf_next  = ovf | step_sat;
                if (stop) begin
                    state_next = ST_HOLD;
                    cnt_d_next = 2'd0;
                    cnt_t_next = 2'd0;
                end else begin
                    state_next = ST_RUN;
                    cnt_d_next = upd_d[1:0];
                    cnt_t_next = upd_t[1:0];
                    drop_next  = drop_err | upd_d[2] | upd_t[2];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fare     <= 16'h0000;
            cnt_d    <= 2'd0;
            cnt_t    <= 2'd0;
            prev_d   <= 1'b0;
            prev_t   <= 1'b0;
            sel      <= SRC_DIST;
            step_q   <= 4'd0;
            ovf      <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_next;
            fare     <= fare_next;
            cnt_d    <= cnt_d_next;
            cnt_t    <= cnt_t_next;
            prev_d   <= add_distance;
            prev_t   <= add_time;
            sel      <= sel_next;
            step_q   <= step_next;
            ovf      <= ovf_next;
            drop_err <= drop_next;
        end
    end

    assign running   = (state == ST_RUN) || (state == ST_ADD);
    assign busy      = (state == ST_ADD);
    assign fsm_state = state;

endmodule

// File: tb/tb_fare_meter_ctrl.sv
// Bench for fare_meter_ctrl: directed trips plus randomized pulses, checked each
// cycle against a decimal-arithmetic model of the meter's tariff rules.
module tb_fare_meter_ctrl;
    import fare_meter_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        start, stop, add_distance, add_time;
    logic [15:0] fare;
    logic        running, busy, ovf, drop_err;
    fare_state_e fsm_state;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    // model: fare kept as a plain decimal integer
    localparam int M_IDLE = 0, M_RUN = 1, M_ADD = 2, M_HOLD = 3;
    int m_mode;
    int m_fare;
    int m_cd, m_ct;
    bit m_serve_dist, m_ovf, m_drop, m_pd, m_pt;

    fare_meter_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .add_distance (add_distance),
        .add_time     (add_time),
        .fare         (fare),
        .running      (running),
        .busy         (busy),
        .ovf          (ovf),
        .drop_err     (drop_err),
        .fsm_state    (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_fare = 0; m_cd = 0; m_ct = 0;
        m_serve_dist = 1'b1; m_ovf = 1'b0; m_drop = 1'b0; m_pd = 1'b0; m_pt = 1'b0;
    endtask

    task automatic model_count(input bit ev_d, input bit ev_t);
        if (ev_d) begin
            if (m_cd == 3) m_drop = 1'b1; else m_cd++;
        end
        if (ev_t) begin
            if (m_ct == 3) m_drop = 1'b1; else m_ct++;
        end
    endtask

    task automatic model_edge(input bit s, input bit p, input bit d, input bit t);
        bit ev_d, ev_t;
        ev_d = d && !m_pd;
        ev_t = t && !m_pt;
        m_pd = d;
        m_pt = t;
        case (m_mode)
            M_IDLE, M_HOLD: begin
                if (s && !p) begin
                    m_mode = M_RUN; m_fare = 80; m_cd = 0; m_ct = 0;
                    m_ovf = 1'b0; m_drop = 1'b0;
                end
            end
            M_RUN: begin
                if (p) begin
                    m_mode = M_HOLD; m_cd = 0; m_ct = 0;
                end else begin
                    if (m_cd > 0 || m_ct > 0) begin
                        m_serve_dist = (m_cd > 0);
                        m_mode = M_ADD;
                    end
                    model_count(ev_d, ev_t);
                end
            end
            default: begin
                m_fare += m_serve_dist ? 8 : 4;
                if (m_fare > 9999) begin
                    m_fare = 9999;
                    m_ovf = 1'b1;
                end
                exp_q.push_back(to_bcd(m_fare));
                if (m_serve_dist) m_cd--; else m_ct--;
                if (p) begin
                    m_mode = M_HOLD; m_cd = 0; m_ct = 0;
                end else begin
                    m_mode = M_RUN;
                    model_count(ev_d, ev_t);
                end
            end
        endcase
    endtask

    // one clock: drive, edge, update model, compare #1 after the edge
    task automatic cycle(input bit s, input bit p, input bit d, input bit t);
        logic was_busy;
        start = s; stop = p; add_distance = d; add_time = t;
        was_busy = busy;
        @(posedge clk);
        model_edge(s, p, d, t);
        #1;
        check_eq("fare", fare, to_bcd(m_fare));
        check_eq("running", running, (m_mode == M_RUN || m_mode == M_ADD));
        check_eq("busy", busy, (m_mode == M_ADD));
        check_eq("ovf", ovf, m_ovf);
        check_eq("drop_err", drop_err, m_drop);
        if (was_busy) begin
            check_eq("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("sb_add_result", fare, exp_q.pop_front());
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic new_trip();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_fare"}, fare, 16'h0000);
        check_eq({tag, "_running"}, running, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_ovf"}, ovf, 1'b0);
        check_eq({tag, "_drop"}, drop_err, 1'b0);
    endtask

    initial begin
        int busy_seen;
        rst = 1'b0; start = 1'b0; stop = 1'b0; add_distance = 1'b0; add_time = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b1;

        // single distance pulse: 0080 then 0088 on the 3rd edge, busy one cycle
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("start_fare", fare, 16'h0080);
        busy_seen = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        busy_seen += busy;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        busy_seen += busy;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        busy_seen += busy;
        check_eq("lone_fare", fare, 16'h0088);
        idle_cycles(3);
        busy_seen += busy;
        check_eq("lone_busy_cycles", busy_seen, 1);

        // simultaneous distance and time: distance first, time next
        new_trip();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("both_first", fare, 16'h0088);
        cycle(1'b0, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("both_second", fare, 16'h0092);

        // sustained pulsing on both sources starves time and overflows its counter
        new_trip();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle_cycles(16);
        check_eq("burst_drop", drop_err, 1'b1);

        // stop during ADD: the add lands, then HOLD ignores pulses
        new_trip();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("stop_add_fare", fare, 16'h0088);
        check_eq("stop_add_running", running, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("hold_frozen", fare, 16'h0088);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("start_stop_hold", running, 1'b0);

        // randomized trips
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        idle_cycles(10);

        // climb to 9996, then one distance event saturates
        new_trip();
        for (int k = 0; k < 1239; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            idle_cycles(2);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);
        check_eq("near_limit", fare, 16'h9996);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        check_eq("sat_fare", fare, 16'h9999);
        check_eq("sat_ovf", ovf, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        check_eq("sat_keep", fare, 16'h9999);
        new_trip();
        check_eq("restart_fare", fare, 16'h0080);
        check_eq("restart_ovf", ovf, 1'b0);

        // asynchronous reset in the middle of a trip
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        exp_q.delete();
        #2;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(3);
        check_eq("after_rst_idle", running, 1'b0);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
